// File: rtl/mmss_countdown_timer.sv
// mmss_countdown_timer
//   MM:SS countdown timer fed by a keypad encoder and a 1 Hz pulse train.
//   Keypad digits shift in from the right while idle. The time counts down
//   once per rising edge of pgt_1Hz while running.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   D[3:0], loadn      keypad BCD digit and active-low digit strobe
//   pgt_1Hz            1 Hz square wave; its rising edge decrements the time
//   start, stop, clear debounced active-high level controls
//   sec_ones..min_tens registered BCD display digits
//   counting, done     registered status (RUN / DONE state)
//   enablen            registered keypad enable, low only while idle
module mmss_countdown_timer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       counting,
  output logic       done,
  output logic       enablen
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] loadn_sync;
  logic [SYNC_STAGES-1:0] pgt_sync;
  logic                   loadn_prev;
  logic                   pgt_prev;
  logic                   load_evt;
  logic                   tick_evt;

  logic [3:0] so_nxt, st_nxt, mo_nxt, mt_nxt;
  logic [3:0] so_dec, st_dec, mo_dec, mt_dec;
  logic       time_zero;
  logic       dec_zero;

  // Synchronisers and edge detectors, reset to the inactive input level so
  // that reset release never fabricates an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loadn_sync <= '1;
      pgt_sync   <= '0;
      loadn_prev <= 1'b1;
      pgt_prev   <= 1'b0;
    end else begin
      loadn_sync <= {loadn_sync[SYNC_STAGES-2:0], loadn};
      pgt_sync   <= {pgt_sync[SYNC_STAGES-2:0], pgt_1Hz};
      loadn_prev <= loadn_sync[SYNC_STAGES-1];
      pgt_prev   <= pgt_sync[SYNC_STAGES-1];
    end
  end

  assign load_evt = loadn_prev & ~loadn_sync[SYNC_STAGES-1];
  assign tick_evt = ~pgt_prev & pgt_sync[SYNC_STAGES-1];

  assign time_zero = ({min_tens, min_ones, sec_tens, sec_ones} == '0);

  // One-step BCD decrement with borrow ripple; seconds tens restart at 5.
  always_comb begin
    so_dec = sec_ones;
    st_dec = sec_tens;
    mo_dec = min_ones;
    mt_dec = min_tens;
    if (sec_ones != 4'd0) begin
      so_dec = sec_ones - 4'd1;
    end else if (sec_tens != 4'd0) begin
      st_dec = sec_tens - 4'd1;
      so_dec = 4'd9;
    end else if (min_ones != 4'd0) begin
      mo_dec = min_ones - 4'd1;
      st_dec = 4'd5;
      so_dec = 4'd9;
    end else if (min_tens != 4'd0) begin
      mt_dec = min_tens - 4'd1;
      mo_dec = 4'd9;
      st_dec = 4'd5;
      so_dec = 4'd9;
    end
  end

  assign dec_zero = ({mt_dec, mo_dec, st_dec, so_dec} == '0);

  // Next-state / next-digit logic. Priority: clear > stop > start > tick/load.
  always_comb begin
    state_nxt = state;
    so_nxt    = sec_ones;
    st_nxt    = sec_tens;
    mo_nxt    = min_ones;
    mt_nxt    = min_tens;
    if (clear) begin
      state_nxt = S_IDLE;
      so_nxt    = '0;
      st_nxt    = '0;
      mo_nxt    = '0;
      mt_nxt    = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (stop) begin
            state_nxt = S_IDLE;
          end else if (start) begin
            // Judged on the pre-load digits; a coincident load is dropped.
            if (!time_zero) state_nxt = S_RUN;
          end else if (load_evt && (D <= 4'd9)) begin
            mt_nxt = min_ones;
            mo_nxt = sec_tens;
            st_nxt = sec_ones;
            so_nxt = D;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_nxt = S_PAUSE;
          end else if (tick_evt && !time_zero) begin
            so_nxt = so_dec;
            st_nxt = st_dec;
            mo_nxt = mo_dec;
            mt_nxt = mt_dec;
            if (dec_zero) state_nxt = S_DONE;
          end
        end
        S_PAUSE: begin
          if (!stop && start) state_nxt = S_RUN;
        end
        S_DONE: begin
          if (!stop && start) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, digits and status flags all registered; flags follow next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
      counting <= 1'b0;
      done     <= 1'b0;
      enablen  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sec_ones <= so_nxt;
      sec_tens <= st_nxt;
      min_ones <= mo_nxt;
      min_tens <= mt_nxt;
      counting <= (state_nxt == S_RUN);
      done     <= (state_nxt == S_DONE);
      enablen  <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Testbench for mmss_countdown_timer: directed stimulus with a scoreboard
// queue of expected {digits, counting, done, enablen} snapshots.
module tb_mmss_countdown_timer;

  logic       clk;
  logic       rst;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       counting, done, enablen;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [18:0] val;
  } exp_t;

  exp_t sb[$];

  mmss_countdown_timer #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .D        (D),
    .loadn    (loadn),
    .pgt_1Hz  (pgt_1Hz),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .counting (counting),
    .done     (done),
    .enablen  (enablen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push an expected snapshot: digits as 16'hMMSS, then counting/done/enablen.
  task automatic push(input string tag, input logic [15:0] digits,
                      input logic c, input logic d, input logic e);
    exp_t x;
    x.tag = tag;
    x.val = {digits, c, d, e};
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t        x;
    logic [18:0] obs;
    obs = {min_tens, min_ones, sec_tens, sec_ones, counting, done, enablen};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.val) else begin
        failures++;
        $error("FAIL %s observed=%h required=%h", x.tag, obs, x.val);
      end
    end
  endtask

  task automatic load_digit(input logic [3:0] d, input int hold);
    @(negedge clk);
    D     = d;
    loadn = 1'b0;
    repeat (hold) @(negedge clk);
    loadn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    load_digit(a, 4);
    load_digit(b, 4);
    load_digit(c, 4);
    load_digit(d, 4);
  endtask

  task automatic tick();
    @(negedge clk);
    pgt_1Hz = 1'b1;
    repeat (4) @(negedge clk);
    pgt_1Hz = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; D = 4'd0; loadn = 1'b1; pgt_1Hz = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push("reset", 16'h0000, 0, 0, 0); pop_check();

    // Digit entry and single-event strobe
    load4(4'd1, 4'd2, 4'd3, 4'd0);
    push("load_1230", 16'h1230, 0, 0, 0); pop_check();
    load_digit(4'd4, 50);
    push("held_loadn_one_digit", 16'h2304, 0, 0, 0); pop_check();
    pulse_clear();
    push("clear_idle", 16'h0000, 0, 0, 0); pop_check();

    load_digit(4'd12, 4);
    push("load_d12_ignored", 16'h0000, 0, 0, 0); pop_check();
    load4(4'd1, 4'd2, 4'd3, 4'd4);
    load_digit(4'd5, 4);
    push("five_digits_2345", 16'h2345, 0, 0, 0); pop_check();

    // start+stop together in IDLE: stop wins, stay idle
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    push("start_stop_idle", 16'h2345, 0, 0, 0); pop_check();
    pulse_clear();
    pulse_start();
    push("start_at_zero", 16'h0000, 0, 0, 0); pop_check();

    // Ten second countdown to DONE
    load4(4'd0, 4'd0, 4'd1, 4'd0);
    push("load_0010", 16'h0010, 0, 0, 0); pop_check();
    pulse_start();
    push("run_0010", 16'h0010, 1, 0, 1); pop_check();
    for (int i = 1; i <= 10; i++) begin
      logic [3:0] rem;
      rem = 4'(10 - i);
      tick();
      push($sformatf("count_tick%0d", i), {12'h000, rem}, (i < 10), (i == 10), 1'b1);
      pop_check();
    end
    tick();
    push("done_holds_zero", 16'h0000, 0, 1, 1); pop_check();
    pulse_start();
    push("done_start_idle", 16'h0000, 0, 0, 0); pop_check();

    // Borrow across minutes
    load4(4'd0, 4'd1, 4'd0, 4'd0);
    pulse_start();
    tick();
    push("borrow_0100", 16'h0059, 1, 0, 1); pop_check();
    pulse_clear();
    load4(4'd1, 4'd0, 4'd0, 4'd0);
    pulse_start();
    tick();
    push("borrow_1000", 16'h0959, 1, 0, 1); pop_check();
    pulse_clear();

    // Stop coincident with a tick: tick_evt is live at the second edge after
    // pgt_1Hz is first sampled, so stop is raised for exactly that edge.
    load4(4'd0, 4'd0, 4'd3, 4'd0);
    pulse_start();
    @(negedge clk); pgt_1Hz = 1'b1;
    @(negedge clk);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (2) @(negedge clk); pgt_1Hz = 1'b0;
    repeat (4) @(negedge clk);
    push("stop_with_tick", 16'h0030, 0, 0, 1); pop_check();
    tick(); tick(); tick();
    push("pause_holds", 16'h0030, 0, 0, 1); pop_check();
    pulse_start();
    push("resume", 16'h0030, 1, 0, 1); pop_check();
    tick();
    push("resume_tick", 16'h0029, 1, 0, 1); pop_check();
    load_digit(4'd7, 4);
    push("load_ignored_run", 16'h0029, 1, 0, 1); pop_check();
    pulse_clear();

    // Clear while running
    load4(4'd0, 4'd0, 4'd4, 4'd5);
    pulse_start();
    pulse_clear();
    push("clear_run", 16'h0000, 0, 0, 0); pop_check();

    // Asynchronous reset mid-count, checked before the next clock edge
    load4(4'd0, 4'd0, 4'd4, 4'd5);
    pulse_start();
    tick();
    push("run_0044", 16'h0044, 1, 0, 1); pop_check();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    push("async_reset", 16'h0000, 0, 0, 0); pop_check();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
